// File: rtl/uart_imem_loader.sv
// UART program loader: receives an 8N1 byte stream, packs bytes little-endian into 32-bit words
// and writes them sequentially into instruction memory while holding the CPU in reset.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  input  logic                  load_en,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]      MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_HDR0, L_HDR1, L_DATA, L_DONE, L_ERR} ld_state_t;

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  rx_state_t        rx_state_r;
  logic [CNT_W-1:0] tick_r;
  logic [2:0]       bit_r;
  logic [7:0]       shift_r;
  logic [7:0]       rx_byte_r;
  logic             rx_valid_r;
  logic             rx_ferr_r;

  ld_state_t             ld_state_r;
  logic [15:0]           cnt_r;
  logic [ADDR_WIDTH-1:0] word_idx_r;
  logic [1:0]            byte_idx_r;
  logic [23:0]           lane_r;

  logic [15:0] hdr_cnt_s;
  logic        last_word_s;

  assign hdr_cnt_s   = {rx_byte_r, cnt_r[7:0]};
  assign last_word_s = (32'(word_idx_r) == (32'(cnt_r) - 32'd1));

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Byte receiver: mid-bit sampling, false-start rejection, one-cycle valid/ferr pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_r <= RX_IDLE;
      tick_r     <= '0;
      bit_r      <= 3'd0;
      shift_r    <= 8'd0;
      rx_byte_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          tick_r <= '0;
          bit_r  <= 3'd0;
          if (prev_r && !sync2_r) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (tick_r == HALF_TICK) begin
            tick_r     <= '0;
            rx_state_r <= sync2_r ? RX_IDLE : RX_DATA;
          end else begin
            tick_r <= tick_r + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (tick_r == FULL_TICK) begin
            tick_r  <= '0;
            shift_r <= {sync2_r, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end else begin
              bit_r <= bit_r + 3'd1;
            end
          end else begin
            tick_r <= tick_r + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (tick_r == FULL_TICK) begin
            tick_r     <= '0;
            rx_state_r <= RX_IDLE;
            if (sync2_r) begin
              rx_valid_r <= 1'b1;
              rx_byte_r  <= shift_r;
            end else begin
              rx_ferr_r <= 1'b1;
            end
          end else begin
            tick_r <= tick_r + CNT_W'(1);
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM; dropping load_en is checked first so an abort beats a same-cycle 4th byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_r <= L_IDLE;
      cnt_r      <= 16'd0;
      word_idx_r <= '0;
      byte_idx_r <= 2'd0;
      lane_r     <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (ld_state_r)
        L_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (load_en) begin
            ld_state_r <= L_HDR0;
            cpu_hold   <= 1'b1;
            word_idx_r <= '0;
            byte_idx_r <= 2'd0;
          end else begin
            cpu_hold <= 1'b0;
          end
        end
        L_HDR0: begin
          if (!load_en) begin
            ld_state_r <= L_IDLE;
            cpu_hold   <= 1'b0;
          end else if (rx_ferr_r) begin
            ld_state_r <= L_ERR;
            err        <= 1'b1;
          end else if (rx_valid_r) begin
            cnt_r[7:0] <= rx_byte_r;
            ld_state_r <= L_HDR1;
          end
        end
        L_HDR1: begin
          if (!load_en) begin
            ld_state_r <= L_IDLE;
            cpu_hold   <= 1'b0;
          end else if (rx_ferr_r) begin
            ld_state_r <= L_ERR;
            err        <= 1'b1;
          end else if (rx_valid_r) begin
            cnt_r <= hdr_cnt_s;
            if (hdr_cnt_s == 16'd0) begin
              ld_state_r <= L_DONE;
              done       <= 1'b1;
            end else if (32'(hdr_cnt_s) > MAX_WORDS) begin
              ld_state_r <= L_ERR;
              err        <= 1'b1;
            end else begin
              ld_state_r <= L_DATA;
            end
          end
        end
        L_DATA: begin
          if (!load_en) begin
            ld_state_r <= L_IDLE;
            cpu_hold   <= 1'b0;
          end else if (rx_ferr_r) begin
            ld_state_r <= L_ERR;
            err        <= 1'b1;
          end else if (rx_valid_r) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx_r;
              imem_wdata <= DATA_WIDTH'({rx_byte_r, lane_r});
              if (last_word_s) begin
                ld_state_r <= L_DONE;
                done       <= 1'b1;
              end else begin
                word_idx_r <= word_idx_r + ADDR_WIDTH'(1);
              end
            end else begin
              // Shifting in from the top leaves lanes ordered {b2,b1,b0} after three bytes.
              lane_r <= {rx_byte_r, lane_r[23:8]};
            end
          end
        end
        L_DONE: begin
          if (!load_en) begin
            ld_state_r <= L_IDLE;
            done       <= 1'b0;
            cpu_hold   <= 1'b0;
          end
        end
        L_ERR: begin
          if (!load_en) begin
            ld_state_r <= L_IDLE;
            err        <= 1'b0;
            cpu_hold   <= 1'b0;
          end
        end
        default: begin
          ld_state_r <= L_IDLE;
          cpu_hold   <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

endmodule
